// File: rtl/atomik_uart_pkg.sv
// Shared UART framing definitions for the telemetry transmitter and the genome loader.
package atomik_uart_pkg;

    localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
    localparam int unsigned FRAME_BYTES     = 7;

    localparam logic [7:0]  TYPE_CORE_DATA  = 8'h01;
    localparam logic [7:0]  TYPE_STATUS     = 8'h02;
    localparam logic [7:0]  TYPE_GENOME_ACK = 8'h03;

    typedef enum logic [1:0] {
        BYTE_IDLE  = 2'd0,
        BYTE_START = 2'd1,
        BYTE_DATA  = 2'd2,
        BYTE_STOP  = 2'd3
    } byte_state_e;

    typedef enum logic {
        FRM_IDLE = 1'b0,
        FRM_SEND = 1'b1
    } frame_state_e;

    // Frame checksum: XOR of type and the four payload bytes (sync byte excluded).
    function automatic logic [7:0] frame_checksum(input logic [7:0]  ftype,
                                                  input logic [31:0] data);
        return ftype ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A start request in IDLE, or during the last stop-bit
// cycle, begins a new start bit on the very next edge so bytes run gap-free.
module uart_byte_tx
    import atomik_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 703
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       start,
    output logic       done,
    output logic       line
);

    if (CLKS_PER_BIT < 2) begin : g_cfg_check
        $error("uart_byte_tx: CLKS_PER_BIT must be at least 2");
    end

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    // done is registered, so it is raised one cycle ahead of the last count
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BIT - 2);

    byte_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             line_q;
    logic             done_q;

    // Bit-timing FSM: holds each bit CLKS_PER_BIT cycles and drives the line register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BYTE_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            line_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                BYTE_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        shift_q <= byte_in;
                        line_q  <= 1'b0;
                        state_q <= BYTE_START;
                    end else begin
                        line_q  <= 1'b1;
                    end
                end
                BYTE_START: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q     <= '0;
                        bit_idx_q <= 3'd0;
                        line_q    <= shift_q[0];
                        state_q   <= BYTE_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BYTE_DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            line_q  <= 1'b1;
                            state_q <= BYTE_STOP;
                        end else begin
                            line_q    <= shift_q[1];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BYTE_STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        if (start) begin
                            shift_q <= byte_in;
                            line_q  <= 1'b0;
                            state_q <= BYTE_START;
                        end else begin
                            line_q  <= 1'b1;
                            state_q <= BYTE_IDLE;
                        end
                    end else begin
                        cnt_q  <= cnt_q + CNT_W'(1);
                        done_q <= (cnt_q == PRE_LAST_CNT);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    line_q  <= 1'b1;
                    state_q <= BYTE_IDLE;
                end
            endcase
        end
    end

    assign done = done_q;
    assign line = line_q;

endmodule

// File: rtl/uart_telemetry_tx.sv
// Telemetry framer: latches one type/data word per handshake and sends
// A5, type, data[31:24..7:0], checksum as back-to-back 8N1 bytes.
module uart_telemetry_tx
    import atomik_uart_pkg::*;
#(
    parameter int CLK_FREQ  = 81_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_type,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        uart_tx,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [2:0] LAST_IDX     = 3'(FRAME_BYTES - 1);

    frame_state_e state_q;
    logic [2:0]   idx_q;
    logic [7:0]   type_q;
    logic [31:0]  data_q;
    logic         ready_q;
    logic         busy_q;
    logic [15:0]  frames_q;

    logic [7:0]   checksum_s;
    logic [2:0]   next_idx_s;
    logic [7:0]   byte_s;
    logic         start_s;
    logic         byte_done_s;
    logic         line_s;

    assign checksum_s = frame_checksum(type_q, data_q);

    // Byte mux: picks the byte that starts on the next edge, and when to start it.
    always_comb begin
        start_s    = 1'b0;
        next_idx_s = 3'd0;
        byte_s     = SYNC_BYTE;
        if (state_q == FRM_IDLE) begin
            start_s    = tx_valid;
            next_idx_s = 3'd0;
        end else begin
            start_s    = byte_done_s && (idx_q != LAST_IDX);
            next_idx_s = idx_q + 3'd1;
        end
        case (next_idx_s)
            3'd0:    byte_s = SYNC_BYTE;
            3'd1:    byte_s = type_q;
            3'd2:    byte_s = data_q[31:24];
            3'd3:    byte_s = data_q[23:16];
            3'd4:    byte_s = data_q[15:8];
            3'd5:    byte_s = data_q[7:0];
            3'd6:    byte_s = checksum_s;
            default: byte_s = SYNC_BYTE;
        endcase
    end

    // Frame FSM: accepts a word in IDLE, walks the byte index, counts finished frames.
    // Reset clears the counter; a frame abandoned by reset is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FRM_IDLE;
            idx_q    <= 3'd0;
            type_q   <= 8'h00;
            data_q   <= 32'h0000_0000;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            frames_q <= 16'h0000;
        end else begin
            case (state_q)
                FRM_IDLE: begin
                    idx_q <= 3'd0;
                    if (tx_valid) begin
                        type_q  <= tx_type;
                        data_q  <= tx_data;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= FRM_SEND;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                FRM_SEND: begin
                    if (byte_done_s) begin
                        if (idx_q == LAST_IDX) begin
                            ready_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            frames_q <= frames_q + 16'd1;
                            state_q  <= FRM_IDLE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= FRM_IDLE;
                end
            endcase
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .rst     (rst),
        .byte_in (byte_s),
        .start   (start_s),
        .done    (byte_done_s),
        .line    (line_s)
    );

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign uart_tx     = line_s;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_uart_telemetry_tx.sv
// Self-checking bench for uart_telemetry_tx: a mid-bit line receiver pops
// expected bytes from a scoreboard queue filled as frames are requested.
module tb_uart_telemetry_tx;
    import atomik_uart_pkg::*;

    localparam int CPB   = 16;
    localparam int CPB_W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tx_type;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        uart_tx;
    logic        busy;
    logic [15:0] frames_sent;

    logic        rst_w;
    logic        tx_valid_w;
    logic        tx_ready_w;
    logic        uart_tx_w;
    logic        busy_w;
    logic [15:0] frames_sent_w;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q[$];
    bit          rx_en    = 1'b0;

    // free-running clock, period 10
    always #5 clk = ~clk;

    uart_telemetry_tx #(.CLK_FREQ(1600), .BAUD_RATE(100)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .tx_type     (tx_type),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .uart_tx     (uart_tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    uart_telemetry_tx #(.CLK_FREQ(200), .BAUD_RATE(100)) u_dut_w (
        .clk         (clk),
        .rst         (rst_w),
        .tx_type     (TYPE_STATUS),
        .tx_data     (32'h0000_0001),
        .tx_valid    (tx_valid_w),
        .tx_ready    (tx_ready_w),
        .uart_tx     (uart_tx_w),
        .busy        (busy_w),
        .frames_sent (frames_sent_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [7:0] tb_csum(input logic [7:0] t, input logic [31:0] d);
        logic [7:0] c;
        c = t;
        for (int i = 0; i < 4; i++) c = c ^ d[8*i +: 8];
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] t, input logic [31:0] d, input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        exp_q.push_back(t);
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(cs);
    endtask

    // counts negedges with tx_ready low, starting from the current (already low) one
    task automatic measure_busy(input bit mutate, output int cycles);
        cycles = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) break;
            cycles++;
            if (mutate && cycles == 300) begin
                tx_data = 32'h1234_5678;
                tx_type = 8'h55;
            end
        end
    endtask

    task automatic wrap_frame(input logic [15:0] exp_cnt, input string tag);
        int c;
        tx_valid_w = 1'b1;
        @(negedge clk);
        tx_valid_w = 1'b0;
        c = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_ready_w === 1'b1) break;
            c++;
        end
        check_eq({tag, "_busy_cycles"}, 32'(c), 32'd140);
        check_eq(tag, 32'(frames_sent_w), 32'(exp_cnt));
    endtask

    // line receiver: sample mid-bit, abandon the byte if reset appears
    initial begin : rx_proc
        logic [7:0] sh;
        logic       ok;
        logic [7:0] e;
        sh = 8'h00;
        forever begin
            @(negedge clk);
            if (rx_en && rst === 1'b0 && uart_tx === 1'b0) begin
                ok = 1'b1;
                for (int k = 0; k < 10 && ok; k++) begin
                    for (int j = 0; j < ((k == 0) ? CPB / 2 : CPB); j++) begin
                        @(negedge clk);
                        if (rst !== 1'b0) ok = 1'b0;
                    end
                    if (ok) begin
                        if (k == 0) begin
                            check_eq("rx_start_bit", 32'(uart_tx), 32'd0);
                        end else if (k < 9) begin
                            sh = {uart_tx, sh[7:1]};
                        end else begin
                            check_eq("rx_stop_bit", 32'(uart_tx), 32'd1);
                            if (exp_q.size() == 0) begin
                                check_eq("rx_extra_byte", 32'(sh), 32'h100);
                            end else begin
                                e = exp_q.pop_front();
                                check_eq("rx_byte", 32'(sh), 32'(e));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int  cnt;
        bit  any_low;
        rst        = 1'b1;
        tx_valid   = 1'b1;
        tx_type    = TYPE_CORE_DATA;
        tx_data    = 32'hDEAD_BEEF;
        rst_w      = 1'b1;
        tx_valid_w = 1'b0;

        // 1: reset with tx_valid held high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
            check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_frames", 32'(frames_sent), 32'd0);
        end

        // 2 + 4: single frame, inputs changed while busy
        rx_en = 1'b1;
        push_frame(8'h01, 32'hDEAD_BEEF, 8'h23);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t2_start_latency", 32'(uart_tx), 32'd0);
        check_eq("t2_ready_low", 32'(tx_ready), 32'd0);
        check_eq("t2_busy_high", 32'(busy), 32'd1);
        tx_valid = 1'b0;
        measure_busy(1'b1, cnt);
        check_eq("t2_busy_cycles", 32'(cnt), 32'd1120);
        check_eq("t2_frames", 32'(frames_sent), 32'd1);
        repeat (4) @(negedge clk);
        check_eq("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // 3: back-to-back with tx_valid held
        tx_type  = TYPE_CORE_DATA;
        tx_data  = 32'hDEAD_BEEF;
        tx_valid = 1'b1;
        push_frame(8'h01, 32'hDEAD_BEEF, 8'h23);
        @(negedge clk);
        check_eq("t3_first_start", 32'(uart_tx), 32'd0);
        tx_type = TYPE_STATUS;
        tx_data = 32'h0000_0000;
        push_frame(8'h02, 32'h0000_0000, 8'h02);
        measure_busy(1'b0, cnt);
        check_eq("t3_busy_cycles_1", 32'(cnt), 32'd1120);
        check_eq("t3_gap_line_high", 32'(uart_tx), 32'd1);
        @(negedge clk);
        check_eq("t3_second_start", 32'(uart_tx), 32'd0);
        check_eq("t3_second_ready_low", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        measure_busy(1'b0, cnt);
        check_eq("t3_busy_cycles_2", 32'(cnt), 32'd1120);
        check_eq("t3_frames", 32'(frames_sent), 32'd3);
        repeat (4) @(negedge clk);
        check_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset mid-frame (counter starts from a clean reset at 0)
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("t5_pre_frames", 32'(frames_sent), 32'd0);
        tx_type  = TYPE_GENOME_ACK;
        tx_data  = 32'hCAFE_F00D;
        tx_valid = 1'b1;
        push_frame(TYPE_GENOME_ACK, 32'hCAFE_F00D, tb_csum(TYPE_GENOME_ACK, 32'hCAFE_F00D));
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (559) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_line_idle", 32'(uart_tx), 32'd1);
        check_eq("t5_ready", 32'(tx_ready), 32'd1);
        check_eq("t5_frames_held", 32'(frames_sent), 32'd0);
        check_eq("t5_bytes_before_rst", 32'(exp_q.size()), 32'd4);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        any_low = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) any_low = 1'b1;
        end
        check_eq("t5_line_quiet", 32'(any_low), 32'd0);
        check_eq("t5_frames_after", 32'(frames_sent), 32'd0);
        tx_type  = TYPE_STATUS;
        tx_data  = 32'h0F1E_2D3C;
        tx_valid = 1'b1;
        push_frame(TYPE_STATUS, 32'h0F1E_2D3C, tb_csum(TYPE_STATUS, 32'h0F1E_2D3C));
        @(negedge clk);
        tx_valid = 1'b0;
        measure_busy(1'b0, cnt);
        check_eq("t5_clean_busy_cycles", 32'(cnt), 32'd1120);
        check_eq("t5_clean_frames", 32'(frames_sent), 32'd1);
        repeat (4) @(negedge clk);
        check_eq("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // 6: counter wrap on the CLKS_PER_BIT=2 instance, preloaded near the top
        rst_w = 1'b0;
        @(negedge clk);
        force u_dut_w.frames_q = 16'hFFFE;
        @(negedge clk);
        release u_dut_w.frames_q;
        @(negedge clk);
        wrap_frame(16'hFFFF, "t6_frames_ffff");
        wrap_frame(16'h0000, "t6_frames_wrap");
        wrap_frame(16'h0001, "t6_frames_0001");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
